// File: rtl/rect80_key_schedule_if.sv
// Bus between the RECTANGLE-80 key schedule and its controller/datapath.
// The master drives load/next requests; the slave (key schedule) returns the round key.
interface rect80_key_schedule_if;
    logic        i_load;
    logic [79:0] iv_key;
    logic        i_next;
    logic [15:0] ov_key0;
    logic [15:0] ov_key1;
    logic [15:0] ov_key2;
    logic [15:0] ov_key3;
    logic        o_key_valid;
    logic        o_last;
    logic [4:0]  ov_round;

    modport master (
        output i_load, iv_key, i_next,
        input  ov_key0, ov_key1, ov_key2, ov_key3, o_key_valid, o_last, ov_round
    );

    modport slave (
        input  i_load, iv_key, i_next,
        output ov_key0, ov_key1, ov_key2, ov_key3, o_key_valid, o_last, ov_round
    );
endinterface

// File: rtl/rect80_key_schedule.sv
// RECTANGLE-80 round-key generator. Keeps the 80-bit key register as five
// 16-bit rows and presents rows 0..3 as the current round key, advancing one
// round per i_next request (K0..K_ROUNDS, the last being the whitening key).
module rect80_key_schedule #(
    parameter int unsigned ROUNDS  = 25,
    parameter logic [4:0]  RC_INIT = 5'h01
) (
    input logic                  i_clk,
    input logic                  i_rst,
    rect80_key_schedule_if.slave bus
);

    localparam logic [4:0] LastRound = 5'(ROUNDS);

    typedef enum logic [1:0] {StIdle, StActive, StDone} state_e;

    state_e            state_q, state_d;
    logic [4:0][15:0]  row_q, row_d;
    logic [4:0]        rc_q, rc_d;
    logic [4:0]        round_q, round_d;

    logic [4:0][15:0]  sb;
    logic [4:0][15:0]  upd;
    logic [3:0]        sb_nib;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        unique case (x)
            4'h0: y = 4'h6;
            4'h1: y = 4'h5;
            4'h2: y = 4'hC;
            4'h3: y = 4'hA;
            4'h4: y = 4'h1;
            4'h5: y = 4'hE;
            4'h6: y = 4'h7;
            4'h7: y = 4'h9;
            4'h8: y = 4'hB;
            4'h9: y = 4'h0;
            4'hA: y = 4'h3;
            4'hB: y = 4'hD;
            4'hC: y = 4'h8;
            4'hD: y = 4'hF;
            4'hE: y = 4'h4;
            default: y = 4'h2;
        endcase
        return y;
    endfunction

    // One key-register update: S-box on columns 0..3, Feistel mix, round constant.
    always_comb begin
        sb     = row_q;
        sb_nib = '0;
        for (int j = 0; j < 4; j++) begin
            sb_nib    = sbox({row_q[3][j], row_q[2][j], row_q[1][j], row_q[0][j]});
            sb[0][j]  = sb_nib[0];
            sb[1][j]  = sb_nib[1];
            sb[2][j]  = sb_nib[2];
            sb[3][j]  = sb_nib[3];
        end
        upd[0] = {sb[0][7:0], sb[0][15:8]} ^ sb[1];
        upd[1] = sb[2];
        upd[2] = sb[3];
        upd[3] = {sb[3][3:0], sb[3][15:4]} ^ sb[4];
        upd[4] = sb[0];
        upd[0][4:0] = upd[0][4:0] ^ rc_q;
    end

    // Next-state logic: load beats next; the final next retires to DONE without updating.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        rc_d    = rc_q;
        round_d = round_q;
        if (bus.i_load) begin
            row_d   = bus.iv_key;
            rc_d    = RC_INIT;
            round_d = '0;
            state_d = StActive;
        end else if (bus.i_next && state_q == StActive) begin
            if (round_q != LastRound) begin
                row_d   = upd;
                rc_d    = {rc_q[3:0], rc_q[4] ^ rc_q[2]};
                round_d = round_q + 5'd1;
            end else begin
                state_d = StDone;
            end
        end
    end

    // State and key register, synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StIdle;
            row_q   <= '0;
            rc_q    <= RC_INIT;
            round_q <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            rc_q    <= rc_d;
            round_q <= round_d;
        end
    end

    // Round key comes straight from the registered rows.
    always_comb begin
        bus.ov_key0     = row_q[0];
        bus.ov_key1     = row_q[1];
        bus.ov_key2     = row_q[2];
        bus.ov_key3     = row_q[3];
        bus.ov_round    = round_q;
        bus.o_key_valid = (state_q == StActive);
        bus.o_last      = (state_q == StActive) && (round_q == LastRound);
    end

endmodule

// File: tb/tb_rect80_key_schedule.sv
// Self-checking bench for rect80_key_schedule: an 80-bit software model of the
// key schedule is compared with the DUT on every falling edge, plus directed
// literal checks and randomized load/next/reset traffic.
module tb_rect80_key_schedule;

    localparam int R = 25;

    logic clk;
    logic rst;
    rect80_key_schedule_if bus ();

    rect80_key_schedule #(
        .ROUNDS  (R),
        .RC_INIT (5'h01)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic chk_en = 1'b0;

    logic [3:0] sbox_tab [16] = '{4'h6, 4'h5, 4'hC, 4'hA, 4'h1, 4'hE, 4'h7, 4'h9,
                                  4'hB, 4'h0, 4'h3, 4'hD, 4'h8, 4'hF, 4'h4, 4'h2};

    // Reference model state
    logic [79:0] m_key;
    logic [4:0]  m_rc;
    int          m_round;
    int          m_state;   // 0 idle, 1 active, 2 done

    function automatic logic [79:0] ks_step(input logic [79:0] k, input logic [4:0] rc);
        logic [15:0] r [5];
        logic [3:0]  n;
        logic [15:0] a;
        logic [15:0] d;
        for (int i = 0; i < 5; i++) r[i] = k[16*i +: 16];
        for (int j = 0; j < 4; j++) begin
            n = {r[3][j], r[2][j], r[1][j], r[0][j]};
            n = sbox_tab[n];
            for (int i = 0; i < 4; i++) r[i][j] = n[i];
        end
        a = ((r[0] << 8) | (r[0] >> 8)) ^ r[1];
        a = a ^ {11'b0, rc};
        d = ((r[3] << 12) | (r[3] >> 4)) ^ r[4];
        return {r[0], d, r[3], r[2], a};
    endfunction

    function automatic logic [4:0] rc_step(input logic [4:0] rc);
        return {rc[3:0], rc[4] ^ rc[2]};
    endfunction

    task automatic check(input string name, input logic [79:0] got, input logic [79:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Model follows the bench's own stimulus.
    always @(posedge clk) begin
        if (rst) begin
            m_key   <= '0;
            m_rc    <= 5'h01;
            m_round <= 0;
            m_state <= 0;
        end else if (bus.i_load) begin
            m_key   <= bus.iv_key;
            m_rc    <= 5'h01;
            m_round <= 0;
            m_state <= 1;
        end else if (bus.i_next && m_state == 1) begin
            if (m_round < R) begin
                m_key   <= ks_step(m_key, m_rc);
                m_rc    <= rc_step(m_rc);
                m_round <= m_round + 1;
            end else begin
                m_state <= 2;
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_key", {16'b0, bus.ov_key3, bus.ov_key2, bus.ov_key1, bus.ov_key0},
                  {16'b0, m_key[63:0]});
            check("cyc_valid", {79'b0, bus.o_key_valid}, {79'b0, m_state == 1});
            check("cyc_last", {79'b0, bus.o_last}, {79'b0, (m_state == 1) && (m_round == R)});
            check("cyc_round", {75'b0, bus.ov_round}, 80'(m_round));
        end
    end

    task automatic cyc(input logic l, input logic [79:0] k, input logic n, input logic r);
        @(negedge clk);
        bus.i_load = l;
        bus.iv_key = k;
        bus.i_next = n;
        rst        = r;
        @(posedge clk);
        #1;
        bus.i_load = 1'b0;
        bus.i_next = 1'b0;
        rst        = 1'b0;
    endtask

    function automatic logic [79:0] rand80();
        logic [79:0] k;
        k = {16'($urandom()), $urandom(), $urandom()};
        return k;
    endfunction

    function automatic logic [79:0] dut_key();
        return {16'b0, bus.ov_key3, bus.ov_key2, bus.ov_key1, bus.ov_key0};
    endfunction

    logic [79:0] key_a;
    logic [79:0] key_b;
    logic [63:0] exp_seq [R+1];
    logic [4:0]  lfsr_exp [5];
    logic [79:0] z80;

    initial begin
        lfsr_exp = '{5'h01, 5'h02, 5'h04, 5'h09, 5'h12};
        z80 = '0;
        rst = 1'b1;
        bus.i_load = 1'b0;
        bus.i_next = 1'b0;
        bus.iv_key = '0;

        // Reset for two cycles
        cyc(1'b0, z80, 1'b0, 1'b1);
        chk_en = 1'b1;
        cyc(1'b0, z80, 1'b0, 1'b1);
        check("rst_key", dut_key(), z80);
        check("rst_valid", {79'b0, bus.o_key_valid}, z80);
        check("rst_last", {79'b0, bus.o_last}, z80);
        check("rst_round", {75'b0, bus.ov_round}, z80);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, z80, 1'b1, 1'b0);
            check("idle_next_valid", {79'b0, bus.o_key_valid}, z80);
        end

        // All-zero key, K0 and K1 literals
        cyc(1'b1, z80, 1'b0, 1'b0);
        check("zero_k0", dut_key(), z80);
        check("zero_k0_valid", {79'b0, bus.o_key_valid}, 80'd1);
        check("zero_k0_round", {75'b0, bus.ov_round}, 80'd0);
        cyc(1'b0, z80, 1'b1, 1'b0);
        check("zero_k1", dut_key(), 80'h0000_0000_000F_000E);
        check("zero_k1_round", {75'b0, bus.ov_round}, 80'd1);
        check("model_k1", {16'b0, ks_step(z80, 5'h01)}, 80'h0000_0000_000F_000E);

        // Full back-to-back run with a random key
        key_a = rand80();
        cyc(1'b1, key_a, 1'b0, 1'b0);
        exp_seq[0] = m_key[63:0];
        check("lfsr_model_0", {75'b0, m_rc}, {75'b0, lfsr_exp[0]});
        for (int i = 1; i <= R; i++) begin
            cyc(1'b0, z80, 1'b1, 1'b0);
            exp_seq[i] = m_key[63:0];
            if (i < 5) check("lfsr_model", {75'b0, m_rc}, {75'b0, lfsr_exp[i]});
            check("full_round", {75'b0, bus.ov_round}, 80'(i));
            check("full_last", {79'b0, bus.o_last}, {79'b0, i == R});
        end
        cyc(1'b0, z80, 1'b1, 1'b0);
        check("done_valid", {79'b0, bus.o_key_valid}, z80);
        check("done_last", {79'b0, bus.o_last}, z80);
        check("done_key_held", dut_key(), {16'b0, exp_seq[R]});
        cyc(1'b0, z80, 1'b1, 1'b0);
        check("done_next_ignored", dut_key(), {16'b0, exp_seq[R]});

        // Same key with random stalls must give the same sequence
        cyc(1'b1, key_a, 1'b0, 1'b0);
        check("stall_k0", dut_key(), {16'b0, exp_seq[0]});
        for (int i = 1; i <= R; i++) begin
            for (int s = $urandom_range(5); s > 0; s--) cyc(1'b0, z80, 1'b0, 1'b0);
            cyc(1'b0, z80, 1'b1, 1'b0);
            check("stall_seq", dut_key(), {16'b0, exp_seq[i]});
        end

        // Load and next together at round 7
        cyc(1'b1, rand80(), 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) cyc(1'b0, z80, 1'b1, 1'b0);
        key_b = rand80();
        cyc(1'b1, key_b, 1'b1, 1'b0);
        check("coll_k0", dut_key(), {16'b0, key_b[63:0]});
        check("coll_round", {75'b0, bus.ov_round}, 80'd0);
        cyc(1'b0, z80, 1'b1, 1'b0);
        check("coll_k1", dut_key(), {16'b0, ks_step(key_b, 5'h01) & 80'h0_FFFF_FFFF_FFFF_FFFF});

        // Reset at round 12 overrides load and next
        cyc(1'b1, rand80(), 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) cyc(1'b0, z80, 1'b1, 1'b0);
        cyc(1'b1, rand80(), 1'b1, 1'b1);
        check("mrst_key", dut_key(), z80);
        check("mrst_valid", {79'b0, bus.o_key_valid}, z80);
        check("mrst_round", {75'b0, bus.ov_round}, z80);
        cyc(1'b1, key_a, 1'b0, 1'b0);
        check("mrst_reload_k0", dut_key(), {16'b0, exp_seq[0]});
        for (int i = 1; i <= R; i++) cyc(1'b0, z80, 1'b1, 1'b0);
        check("mrst_reload_k25", dut_key(), {16'b0, exp_seq[R]});

        // Random traffic
        for (int c = 0; c < 1500; c++) begin
            int r;
            r = int'($urandom_range(99));
            cyc(r < 8, rand80(), ($urandom_range(99) < 70), r == 99);
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rect80_key_schedule.md
Name: rect80_key_schedule

Overview:
Round-key generator for the round-based RECTANGLE-80 datapath. Holds the 80-bit key register as five 16-bit rows and presents the current 64-bit round key (rows 0..3) directly to the AddRoundKey XOR stage. It advances one round per request and produces K0..K25: 25 round keys plus the final whitening key.

Parameters:
ROUNDS, 25, number of key-register updates; round keys K0..K_ROUNDS are produced.
RC_INIT, 5'h01, initial value of the 5-bit round-constant LFSR.

Ports:
i_clk  input  1  system clock; all state changes on the rising edge
i_rst  input  1  synchronous, active-high reset
i_load  input  1  single-cycle pulse that captures iv_key and starts a schedule
iv_key  input  80  user key; [15:0]=Row0, [31:16]=Row1, [47:32]=Row2, [63:48]=Row3, [79:64]=Row4
i_next  input  1  pulse that advances to the next round key; honoured only in ACTIVE
ov_key0  output  16  Row0 of the current round key
ov_key1  output  16  Row1 of the current round key
ov_key2  output  16  Row2 of the current round key
ov_key3  output  16  Row3 of the current round key
o_key_valid  output  1  high while ov_key0..3 hold a valid round key
o_last  output  1  high while K_ROUNDS (the whitening key) is presented
ov_round  output  5  index of the presented round key, 0..ROUNDS

Behaviour:
- The clock is i_clk. Reset is i_rst: synchronous and active-high. No asynchronous reset.
- State machine has three states: IDLE, ACTIVE, DONE. Reset enters IDLE.
- Reset values: key rows, ov_key0..3, ov_round, o_key_valid and o_last are all 0. The LFSR is reset to RC_INIT.
- i_load in any state:
  - On the next edge, Row0..Row4 <= iv_key slices, LFSR <= RC_INIT, ov_round <= 0, state <= ACTIVE.
  - o_key_valid is 1 from the following cycle. Load-to-K0 latency is 1 cycle.
- ov_key0..3 are driven directly from registered Row0..Row3. There is no extra output stage.
- i_next in ACTIVE with ov_round < ROUNDS performs one update on the next edge:
  1. S-box layer: for column j = 0..3, nibble {Row3[j],Row2[j],Row1[j],Row0[j]} (Row0 is the LSB) goes through S = 6,5,C,A,1,E,7,9,B,0,3,D,8,F,4,2. Columns 4..15 are unchanged.
  2. Generalised Feistel on the S-box outputs R0..R4:
     - Row0' = (R0 <<< 8) ^ R1
     - Row1' = R2
     - Row2' = R3
     - Row3' = (R3 <<< 12) ^ R4
     - Row4' = R0
  3. Round constant: Row0'[4:0] ^= LFSR.
  4. LFSR update: {rc4..rc0} <= {rc3,rc2,rc1,rc0,rc4^rc2}.
  5. ov_round increments.
- o_last is 1 exactly when ACTIVE and ov_round == ROUNDS.
- i_next in ACTIVE with ov_round == ROUNDS:
  - state <= DONE, o_key_valid <= 0, o_last <= 0.
  - Key rows hold their values. No update is performed.
- i_next in IDLE or DONE is ignored.
- i_load and i_next in the same cycle: i_load wins and i_next is dropped.
- i_rst asserted mid-schedule: all state is reset regardless of i_load or i_next in that cycle. Reset has the highest priority.
- No update occurs without i_next. The round key is held indefinitely so the datapath may stall.

Test Plan:
- Reset: hold i_rst for 2 cycles -> all outputs 0, state IDLE; i_next pulses keep o_key_valid = 0.
- All-zero key: load iv_key = 0 -> next cycle K0 = 0000/0000/0000/0000 with o_key_valid = 1 and ov_round = 0. After one i_next, K1 = ov_key0 000E, ov_key1 000F, ov_key2 0000, ov_key3 0000, and ov_round = 1.
- Full run: load, then 25 i_next pulses -> ov_round steps 0..25, with o_last = 1 only at round 25. The 26th i_next -> o_key_valid = 0, state DONE, keys unchanged. Compare all 26 keys against the software model. The LFSR sequence is checked as 01, 02, 04, 09, 12, ...
- Stall: insert random 0..5 idle cycles between i_next pulses -> key sequence is identical to the back-to-back run.
- Collision: i_load and i_next together at round 7 -> K0 of the new key, ov_round = 0, LFSR = 01.
- Mid-run reset: i_rst at round 12 -> next cycle all outputs 0. A new i_load then restarts correctly from K0.
